// File: rtl/frame_regfile.sv
// frame_regfile: windowed register file behind the instruction decoder.
// r0-r3 are global registers. r4-r7 are banked per call frame and selected by fp.
// CALL/RTN move fp, saturating at the ends. Any overflow or underflow sets a sticky stack_err.
module frame_regfile #(
  parameter int WIDTH  = 16,
  parameter int FRAMES = 8,
  parameter int FPW    = $clog2(FRAMES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       rd_addr,
  input  logic [2:0]       rs_addr,
  input  logic [WIDTH-1:0] rd_wrdata,
  input  logic [WIDTH-1:0] rs_wrdata,
  input  logic             rd_wen,
  input  logic             rs_wen,
  input  logic             move_fp,
  input  logic             push_up,
  output logic [WIDTH-1:0] rddata,
  output logic [WIDTH-1:0] rsdata,
  output logic [FPW-1:0]   fp,
  output logic             stack_err
);

  localparam logic [FPW-1:0] FP_MAX  = FPW'(FRAMES - 1);
  localparam logic [FPW-1:0] FP_ZERO = {FPW{1'b0}};
  localparam logic [FPW-1:0] FP_ONE  = FPW'(1);

  logic [WIDTH-1:0] r_g [4];
  logic [WIDTH-1:0] r_w [FRAMES][4];
  logic [FPW-1:0]   r_fp;
  logic             r_stack_err;

  logic             w_call;
  logic             w_rtn;
  logic             w_call_ok;
  logic             w_rtn_ok;
  logic             w_ovf;
  logic             w_unf;
  logic [FPW-1:0]   w_wr_fp;
  logic             w_rd_we_g;
  logic             w_rd_we_w;
  logic             w_rs_we_g;
  logic             w_rs_we_w;
  logic [WIDTH-1:0] w_rddata;
  logic [WIDTH-1:0] w_rsdata;

  // push_up only means something while move_fp is high.
  assign w_call    = move_fp & ~push_up;
  assign w_rtn     = move_fp & push_up;
  assign w_call_ok = w_call & (r_fp != FP_MAX);
  assign w_rtn_ok  = w_rtn  & (r_fp != FP_ZERO);
  assign w_ovf     = w_call & (r_fp == FP_MAX);
  assign w_unf     = w_rtn  & (r_fp == FP_ZERO);

  // A CALL sends windowed writes to the callee frame, so the return PC lands there.
  // An RTN keeps windowed writes in the old frame.
  assign w_wr_fp   = w_call_ok ? (r_fp + FP_ONE) : r_fp;

  // Overflow drops every write. Underflow drops only the windowed ones.
  assign w_rd_we_g = rd_wen & ~rd_addr[2] & ~w_ovf;
  assign w_rd_we_w = rd_wen &  rd_addr[2] & ~w_ovf & ~w_unf;
  assign w_rs_we_g = rs_wen & ~rs_addr[2] & ~w_ovf;
  assign w_rs_we_w = rs_wen &  rs_addr[2] & ~w_ovf & ~w_unf;

  // Combinational rd read from the current frame, with no write bypass.
  always_comb begin
    w_rddata = {WIDTH{1'b0}};
    if (rd_addr[2]) begin
      w_rddata = r_w[r_fp][rd_addr[1:0]];
    end else begin
      w_rddata = r_g[rd_addr[1:0]];
    end
  end

  // Combinational rs read from the current frame, with no write bypass.
  always_comb begin
    w_rsdata = {WIDTH{1'b0}};
    if (rs_addr[2]) begin
      w_rsdata = r_w[r_fp][rs_addr[1:0]];
    end else begin
      w_rsdata = r_g[rs_addr[1:0]];
    end
  end

  // Register state: reset clear, fp movement, sticky error, and writebacks.
  // The rd write is applied after the rs write, so rd wins a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_g[i] <= {WIDTH{1'b0}};
      end
      for (int f = 0; f < FRAMES; f++) begin
        for (int i = 0; i < 4; i++) begin
          r_w[f][i] <= {WIDTH{1'b0}};
        end
      end
      r_fp        <= FP_ZERO;
      r_stack_err <= 1'b0;
    end else begin
      if (w_ovf || w_unf) begin
        r_stack_err <= 1'b1;
      end else begin
        r_stack_err <= r_stack_err;
      end
      if (w_call_ok) begin
        r_fp <= r_fp + FP_ONE;
      end else if (w_rtn_ok) begin
        r_fp <= r_fp - FP_ONE;
      end else begin
        r_fp <= r_fp;
      end
      if (w_rs_we_g) begin
        r_g[rs_addr[1:0]] <= rs_wrdata;
      end
      if (w_rs_we_w) begin
        r_w[w_wr_fp][rs_addr[1:0]] <= rs_wrdata;
      end
      if (w_rd_we_g) begin
        r_g[rd_addr[1:0]] <= rd_wrdata;
      end
      if (w_rd_we_w) begin
        r_w[w_wr_fp][rd_addr[1:0]] <= rd_wrdata;
      end
    end
  end

  assign rddata    = w_rddata;
  assign rsdata    = w_rsdata;
  assign fp        = r_fp;
  assign stack_err = r_stack_err;

endmodule

// File: tb/tb_frame_regfile.sv
// Scoreboard bench for frame_regfile.
// Stimulus pushes hand-computed expectations for the current cycle.
// A monitor pops and compares them on the falling edge.
module tb_frame_regfile;

  localparam int WIDTH  = 16;
  localparam int FRAMES = 8;
  localparam int FPW    = 3;

  localparam int K_RD  = 0;
  localparam int K_RS  = 1;
  localparam int K_FP  = 2;
  localparam int K_ERR = 3;

  logic             clk;
  logic             reset;
  logic [2:0]       rd_addr;
  logic [2:0]       rs_addr;
  logic [WIDTH-1:0] rd_wrdata;
  logic [WIDTH-1:0] rs_wrdata;
  logic             rd_wen;
  logic             rs_wen;
  logic             move_fp;
  logic             push_up;
  logic [WIDTH-1:0] rddata;
  logic [WIDTH-1:0] rsdata;
  logic [FPW-1:0]   fp;
  logic             stack_err;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  bit   done;

  frame_regfile #(.WIDTH(WIDTH), .FRAMES(FRAMES)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rs_addr(rs_addr),
    .rd_wrdata(rd_wrdata), .rs_wrdata(rs_wrdata),
    .rd_wen(rd_wen), .rs_wen(rs_wen),
    .move_fp(move_fp), .push_up(push_up),
    .rddata(rddata), .rsdata(rsdata),
    .fp(fp), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the outputs are combinational, so every falling edge presents a value to check.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.kind)
        K_RD:    act = rddata;
        K_RS:    act = rsdata;
        K_FP:    act = {13'd0, fp};
        default: act = {15'd0, stack_err};
      endcase
      checks = checks + 1;
      if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
      end
    end
  end

  task automatic drive(input logic rst, input logic [2:0] rda, input logic [2:0] rsa,
                       input logic rdw, input logic [15:0] rdd,
                       input logic rsw, input logic [15:0] rsd,
                       input logic mv, input logic pu);
    reset = rst; rd_addr = rda; rs_addr = rsa;
    rd_wen = rdw; rd_wrdata = rdd; rs_wen = rsw; rs_wrdata = rsd;
    move_fp = mv; push_up = pu;
  endtask

  task automatic expect_v(input int kind, input logic [15:0] v, input string name);
    exp_t e;
    e.kind = kind; e.exp = v; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic check_eq(input logic [15:0] act, input logic [15:0] exp, input string name);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle: reads rd/rs only, with no writes and no fp movement.
  task automatic rd_only(input logic [2:0] rda, input logic [2:0] rsa);
    drive(1'b0, rda, rsa, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; done = 1'b0;
    drive(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    tick();

    // Reset state.
    rd_only(3'd0, 3'd4);
    #1;
    check_eq({13'd0, fp}, 16'd0, "rst_fp_direct");
    check_eq({15'd0, stack_err}, 16'd0, "rst_err_direct");
    check_eq(rddata, 16'h0, "rst_r0_direct");
    expect_v(K_FP, 16'd0, "rst_fp");
    expect_v(K_ERR, 16'd0, "rst_err");
    expect_v(K_RD, 16'h0, "rst_r0");
    tick();

    // Preload r1 and r5, then reset clears them.
    drive(1'b0, 3'd1, 3'd5, 1'b1, 16'h1234, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    rd_only(3'd1, 3'd5);
    expect_v(K_RD, 16'h1234, "preload_r1");
    expect_v(K_RS, 16'hBEEF, "preload_r5");
    tick();
    drive(1'b1, 3'd1, 3'd5, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    rd_only(3'd1, 3'd5);
    expect_v(K_RD, 16'h0, "reset_r1");
    expect_v(K_RS, 16'h0, "reset_r5");
    expect_v(K_FP, 16'd0, "reset_fp");
    expect_v(K_ERR, 16'd0, "reset_err");
    tick();

    // Write collision on r2. push_up is high here with move_fp low, so it must be ignored.
    drive(1'b0, 3'd2, 3'd2, 1'b1, 16'h00AA, 1'b1, 16'h0055, 1'b0, 1'b1);
    expect_v(K_RD, 16'h0, "no_bypass_r2");
    tick();
    rd_only(3'd2, 3'd2);
    expect_v(K_RD, 16'h00AA, "collision_rd");
    expect_v(K_RS, 16'h00AA, "collision_rs");
    expect_v(K_FP, 16'd0, "pushup_ignored_fp");
    tick();

    // Round trip: r7=0x1111 and r3=0x7777 at fp 0.
    drive(1'b0, 3'd7, 3'd3, 1'b1, 16'h1111, 1'b1, 16'h7777, 1'b0, 1'b0);
    tick();
    // CALL with rd=7 <- 0x0042. The read in this cycle still comes from frame 0.
    drive(1'b0, 3'd7, 3'd3, 1'b1, 16'h0042, 1'b0, 16'h0, 1'b1, 1'b0);
    expect_v(K_RD, 16'h1111, "call_cycle_r7");
    tick();
    rd_only(3'd7, 3'd3);
    expect_v(K_FP, 16'd1, "call_fp");
    expect_v(K_RD, 16'h0042, "callee_r7");
    expect_v(K_RS, 16'h7777, "global_r3_fp1");
    tick();
    // RTN: the read shows the return address. A windowed rs write lands in the old frame 1.
    drive(1'b0, 3'd7, 3'd6, 1'b0, 16'h0, 1'b1, 16'h6666, 1'b1, 1'b1);
    expect_v(K_RD, 16'h0042, "rtn_cycle_r7");
    expect_v(K_FP, 16'd1, "rtn_cycle_fp");
    tick();
    rd_only(3'd7, 3'd6);
    expect_v(K_FP, 16'd0, "rtn_fp");
    expect_v(K_RD, 16'h1111, "caller_r7");
    expect_v(K_RS, 16'h0000, "caller_r6");
    tick();
    drive(1'b0, 3'd6, 3'd3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    rd_only(3'd6, 3'd3);
    expect_v(K_RD, 16'h6666, "rtn_write_old_frame");
    expect_v(K_RS, 16'h7777, "global_r3_again");
    tick();

    // Overflow: fp is 1 now, so six more CALLs reach 7.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 3'd4, 3'd4, 1'b1, 16'h4444, 1'b0, 16'h0, 1'b0, 1'b0);
    expect_v(K_FP, 16'd7, "seven_calls_fp");
    expect_v(K_ERR, 16'd0, "seven_calls_err");
    tick();
    drive(1'b0, 3'd4, 3'd1, 1'b1, 16'hDEAD, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    tick();
    rd_only(3'd4, 3'd1);
    expect_v(K_FP, 16'd7, "ovf_fp");
    expect_v(K_ERR, 16'd1, "ovf_err");
    expect_v(K_RD, 16'h4444, "ovf_r4_kept");
    expect_v(K_RS, 16'h0000, "ovf_global_suppressed");
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    tick();
    rd_only(3'd0, 3'd0);
    expect_v(K_FP, 16'd6, "post_ovf_rtn_fp");
    expect_v(K_ERR, 16'd1, "err_sticky");
    tick();

    // Underflow: reset first so the error set is observable.
    drive(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd1, 3'd5, 1'b1, 16'h0009, 1'b1, 16'h0BAD, 1'b1, 1'b1);
    tick();
    rd_only(3'd1, 3'd5);
    expect_v(K_FP, 16'd0, "unf_fp");
    expect_v(K_ERR, 16'd1, "unf_err");
    expect_v(K_RD, 16'h0009, "unf_global_write");
    expect_v(K_RS, 16'h0000, "unf_window_suppressed");
    tick();

    // Reset in the same cycle as a CALL with writes.
    drive(1'b1, 3'd1, 3'd4, 1'b1, 16'h0077, 1'b1, 16'h0088, 1'b1, 1'b0);
    tick();
    rd_only(3'd1, 3'd4);
    expect_v(K_FP, 16'd0, "rst_call_fp");
    expect_v(K_ERR, 16'd0, "rst_call_err");
    expect_v(K_RD, 16'h0000, "rst_call_r1");
    expect_v(K_RS, 16'h0000, "rst_call_r4");
    tick();

    @(negedge clk);
    #1;
    check_eq(16'(sb_q.size()), 16'd0, "scoreboard_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_regfile.md
# frame_regfile

Windowed register file that sits directly downstream of the instruction decoder. It holds the 16-bit general registers that the decoder reads as `rddata`/`rsdata`, and it performs the `rd_wen`/`rs_wen` writebacks selected by the giant mux. It also maintains the frame pointer that CALL and RTN move through the decoder's `move_fp`/`push_up` controls. Registers r0–r3 are global; r4–r7 are banked per call frame, so each subroutine gets a private set of four registers.

## Interface
Parameters:
- `WIDTH`, 16, register data width.
- `FRAMES`, 8, number of call frames; power of two, ≥2. `FPW` = log2(`FRAMES`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `rd_addr`  in  3  logical rd index.
- `rs_addr`  in  3  logical rs index.
- `rd_wrdata`  in  WIDTH  rd write data (giant mux output).
- `rs_wrdata`  in  WIDTH  rs write data (PLD B path).
- `rd_wen`  in  1  write rd this cycle.
- `rs_wen`  in  1  write rs this cycle.
- `move_fp`  in  1  frame pointer moves this cycle.
- `push_up`  in  1  direction when `move_fp`=1: 0 = CALL (fp+1), 1 = RTN (fp−1).
- `rddata`  out  WIDTH  combinational read of rd in the current frame.
- `rsdata`  out  WIDTH  combinational read of rs in the current frame.
- `fp`  out  FPW  current frame pointer.
- `stack_err`  out  1  sticky overflow/underflow flag.

## Operation
- **Storage.**
  - Globals are `g[0..3]`.
  - Windows are `w[0..FRAMES-1][0..3]`.
  - A logical index below 4 maps to `g[idx]`.
  - A logical index of 4 or more maps to `w[frame][idx-4]`.
- **Reads.**
  - `rddata` and `rsdata` are purely combinational from stored state, using the current `fp`.
  - There is no write-to-read bypass: a write becomes visible the cycle after its edge.
- **Plain write** (`move_fp`=0). At the edge, `rd_wen` writes `rd_wrdata` and `rs_wen` writes `rs_wrdata`, both into frame `fp`.
- **Write collision.** If both enables are set and they resolve to the same physical register, the rd write wins.
- **CALL** (`move_fp`=1, `push_up`=0, `fp` < FRAMES−1):
  - `fp` becomes `fp`+1.
  - Windowed rd/rs writes in the same cycle target frame `fp`+1, so the return PC lands in the callee frame.
  - Global writes are unaffected.
  - The new frame keeps its stale contents; there is no clearing.
- **RTN** (`move_fp`=1, `push_up`=1, `fp` > 0):
  - `fp` becomes `fp`−1.
  - Reads that cycle still come from the old frame, so `rddata` carries the return address.
  - Any same-cycle windowed write targets the old frame.
- **Overflow.** CALL with `fp` = FRAMES−1:
  - `stack_err` is set to 1.
  - `fp` is unchanged.
  - All writes that cycle are suppressed.
- **Underflow.** RTN with `fp` = 0:
  - `stack_err` is set to 1.
  - `fp` is unchanged.
  - Windowed writes are suppressed; global writes proceed.
- **Error flag.** `stack_err` is sticky and clears only on `reset`.
- **Ignored input.** `push_up` has no effect when `move_fp`=0.

## Timing
- **Reset.** Synchronous and active-high. At the first edge with `reset`=1:
  - All `g` and `w` registers become 0.
  - `fp` becomes 0.
  - `stack_err` becomes 0.
- **Reset priority.** `reset` overrides every write and `move_fp` in the same cycle, including mid-CALL.
- **Read latency.** Zero cycles, combinational from `rd_addr`/`rs_addr` and `fp`.
- **Write and fp latency.** One edge. A write or fp change at edge N is visible on the reads after edge N.
- **Throughput.** One CALL/RTN per cycle; back-to-back CALL, RTN, CALL is legal with no bubbles.
- **Arithmetic.** `fp` is FPW bits wide with no wrap; the saturation rules above always apply.
- **Data width.** Writes are full WIDTH. There is no byte masking.

## Test plan
- **Reset clears state:** assert `reset` 1 cycle after preloading r1=0x1234 and r5=0xBEEF → r1=0, r5=0, `fp`=0, `stack_err`=0.
- **Write collision:** write r2 ← 0x00AA (`rd_wen`) and r2 ← 0x0055 (`rs_wen`) in the same cycle → next cycle `rddata`(r2)=0x00AA.
- **CALL/RTN round trip:**
  - Start at `fp`=0 with r7=0x1111.
  - Issue CALL with `rd_wen`, rd=7, `rd_wrdata`=0x0042 → `fp`=1, r7=0x0042.
  - Issue RTN with rd=7 → `rddata`=0x0042 during the RTN cycle; after the edge `fp`=0 and r7=0x1111.
- **Globals shared across frames:** write r3=0x7777 at `fp`=0, then CALL → at `fp`=1, r3 still reads 0x7777.
- **Overflow:**
  - Issue 7 CALLs → `fp`=7.
  - An 8th CALL with `rd_wen` to r4 → `fp`=7, `stack_err`=1, r4 unchanged.
  - Then RTN → `fp`=6, with `stack_err` still 1.
- **Underflow and reset mid-operation:**
  - RTN at `fp`=0 with `rd_wen` to r1=0x0009 → `fp`=0, `stack_err`=1, r1=0x0009.
  - Then `reset` asserted in the same cycle as a CALL → `fp`=0, `stack_err`=0.
